// File: rtl/snes_pad_pkg.sv
// Shared SNES controller definitions: button bit map, frame length and
// the transmitter state encoding. The gamepad receiver imports the same map.
package snes_pad_pkg;

    // Length of one serial frame, in bits
    localparam int FRAME_LEN = 16;
    // Bit counter width; it must be able to hold FRAME_LEN itself
    localparam int CNT_W     = 5;

    // Button positions within the 16-bit word (1 = pressed)
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TAIL  = 2'd3
    } padState_e;

    // A frame is in progress from latch capture until the last bit has shifted
    function automatic logic isBusy(input padState_e s);
        return (s == ST_LOAD) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/snes_pad_sync.sv
// Multi-flop synchronizer for one console pin, with registered one-cycle
// rise and fall pulses taken from the last two synchronizer stages.
// STAGES must be at least 2.
module snes_pad_sync #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              rise_q;
    logic              fall_q;

    // Shift the pin through the chain; reset parks it at the idle level so
    // the first cycles after release never report a phantom edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{IDLE_LEVEL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
            fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/snes_pad_tx.sv
// SNES controller-side transmitter: captures a staged button word on the
// console latch and shifts it out active-low on each console clock rise.
module snes_pad_tx
    import snes_pad_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic TAIL_LEVEL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] buttons,
    input  logic        buttons_we,
    input  logic        pad_latch,
    input  logic        pad_clk,
    output logic        pad_data,
    output logic        busy,
    output logic        frame_done,
    output logic        stale
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);

    padState_e        state_q, state_d;
    logic [15:0]      staging_q, staging_d;
    logic [15:0]      shiftReg_q, shiftReg_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic             padData_q, padData_d;
    logic             frameDone_q, frameDone_d;
    logic             stale_q, stale_d;

    logic latchRise;
    logic latchFall;
    logic clkRise;
    // The console samples data on clock falls, so the transmitter never acts on them
    logic unusedClkFall;
    logic busyNow;

    snes_pad_sync #(
        .STAGES     (SYNC_STAGES),
        .IDLE_LEVEL (1'b0)
    ) u_latchSync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (pad_latch),
        .rise_o (latchRise),
        .fall_o (latchFall)
    );

    snes_pad_sync #(
        .STAGES     (SYNC_STAGES),
        .IDLE_LEVEL (1'b1)
    ) u_clkSync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (pad_clk),
        .rise_o (clkRise),
        .fall_o (unusedClkFall)
    );

    assign busyNow = isBusy(state_q);

    // State, shift register, counter and flags: next values from the pin edges
    always_comb begin
        state_d     = state_q;
        staging_d   = staging_q;
        shiftReg_d  = shiftReg_q;
        bitCnt_d    = bitCnt_q;
        frameDone_d = 1'b0;
        stale_d     = stale_q;

        if (buttons_we) begin
            staging_d = buttons;
            if (busyNow) begin
                stale_d = 1'b1;
            end
        end

        case (state_q)
            ST_LOAD: begin
                if (latchFall) begin
                    state_d = ST_SHIFT;
                end else begin
                    shiftReg_d = staging_q;
                end
            end
            ST_SHIFT: begin
                if (clkRise) begin
                    shiftReg_d = shiftReg_q >> 1;
                    if (bitCnt_q < FULL_CNT) begin
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                    if (bitCnt_q == LAST_BIT) begin
                        state_d     = ST_TAIL;
                        frameDone_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        // A new latch always wins: it captures the old staging word and
        // abandons whatever frame was in flight
        if (latchRise) begin
            shiftReg_d  = staging_q;
            bitCnt_d    = '0;
            state_d     = ST_LOAD;
            frameDone_d = 1'b0;
            stale_d     = buttons_we;
        end
    end

    // Output data level for the next cycle, taken from the current state and bit
    always_comb begin
        padData_d = 1'b1;
        case (state_q)
            ST_LOAD, ST_SHIFT: padData_d = ~shiftReg_q[0];
            ST_TAIL:           padData_d = TAIL_LEVEL;
            default:           padData_d = 1'b1;
        endcase
    end

    // Register everything; synchronous reset returns to an idle, all-released pad
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            staging_q   <= '0;
            shiftReg_q  <= '0;
            bitCnt_q    <= '0;
            padData_q   <= 1'b1;
            frameDone_q <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            staging_q   <= staging_d;
            shiftReg_q  <= shiftReg_d;
            bitCnt_q    <= bitCnt_d;
            padData_q   <= padData_d;
            frameDone_q <= frameDone_d;
            stale_q     <= stale_d;
        end
    end

    assign pad_data   = padData_q;
    assign busy       = busyNow;
    assign frame_done = frameDone_q;
    assign stale      = stale_q;

endmodule

// File: tb/tb_snes_pad_tx.sv
// Self-checking bench for snes_pad_tx: directed frames plus randomized
// console traffic against a frame-level model of what the console should read.
`timescale 1ns/1ps
module tb_snes_pad_tx;

    localparam logic TAIL = 1'b0;
    localparam int   HOLD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] buttons = '0;
    logic        buttonsWe = 1'b0;
    logic        padLatch = 1'b0;
    logic        padClk = 1'b1;

    logic padData2, busy2, frameDone2, stale2;
    logic padData3, busy3, frameDone3, stale3;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;

    // Frame-level model: which word the console is reading and how far along
    logic [15:0] mStaging = '0;
    logic [15:0] mWord    = '0;
    int          mRises   = 0;
    bit          mActive  = 1'b0;
    bit          mLatchHigh = 1'b0;
    bit          mClkHigh   = 1'b1;
    bit          mStale   = 1'b0;
    int          mDone    = 0;

    snes_pad_tx #(.SYNC_STAGES(2), .TAIL_LEVEL(TAIL)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .buttons    (buttons),
        .buttons_we (buttonsWe),
        .pad_latch  (padLatch),
        .pad_clk    (padClk),
        .pad_data   (padData2),
        .busy       (busy2),
        .frame_done (frameDone2),
        .stale      (stale2)
    );

    snes_pad_tx #(.SYNC_STAGES(3), .TAIL_LEVEL(TAIL)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .buttons    (buttons),
        .buttons_we (buttonsWe),
        .pad_latch  (padLatch),
        .pad_clk    (padClk),
        .pad_data   (padData3),
        .busy       (busy3),
        .frame_done (frameDone3),
        .stale      (stale3)
    );

    always #5 clk = ~clk;

    // Count cycles with frame_done high so a stretched pulse shows up as extra
    always @(negedge clk) begin
        if (frameDone2 === 1'b1) doneCount++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic expPad();
        if (!mActive) return 1'b1;
        if (mRises < 16) return ~mWord[mRises];
        return TAIL;
    endfunction

    function automatic logic expBusy();
        return mActive && (mRises < 16);
    endfunction

    function automatic void modelLatch(input logic level);
        if (level && !mLatchHigh) begin
            mActive = 1'b1;
            mWord   = mStaging;
            mRises  = 0;
            mStale  = 1'b0;
        end
        mLatchHigh = level;
    endfunction

    function automatic void modelClk(input logic level);
        if (level && !mClkHigh && mActive && !mLatchHigh && mRises < 16) begin
            mRises++;
            if (mRises == 16) mDone++;
        end
        mClkHigh = level;
    endfunction

    function automatic void modelWrite(input logic [15:0] val);
        if (expBusy()) mStale = 1'b1;
        mStaging = val;
        if (mActive && mLatchHigh) mWord = val;
    endfunction

    function automatic void modelReset();
        mActive  = 1'b0;
        mStaging = '0;
        mWord    = '0;
        mRises   = 0;
        mStale   = 1'b0;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, " pad_data"}, padData2, expPad());
        checkOutput({tag, " pad_data(n=3)"}, padData3, expPad());
        checkOutput({tag, " busy"}, busy2, expBusy());
        checkOutput({tag, " stale"}, stale2, mStale);
        checkOutput({tag, " frame_done count"}, doneCount, mDone);
    endtask

    task automatic applyStimulus(input bit isLatch, input logic level);
        @(negedge clk);
        if (isLatch) begin
            padLatch = level;
            modelLatch(level);
        end else begin
            padClk = level;
            modelClk(level);
        end
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic writeButtons(input logic [15:0] val);
        @(negedge clk);
        buttons   = val;
        buttonsWe = 1'b1;
        @(negedge clk);
        buttonsWe = 1'b0;
        modelWrite(val);
        repeat (3) @(negedge clk);
    endtask

    task automatic clkPulse(input string tag);
        applyStimulus(1'b0, 1'b0);
        checkAll({tag, " fall"});
        applyStimulus(1'b0, 1'b1);
        checkAll({tag, " rise"});
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        padLatch = 1'b0;
        padClk   = 1'b1;
        mLatchHigh = 1'b0;
        mClkHigh   = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
    endtask

    // Move one pin at a random phase and count clock edges until pad_data moves
    task automatic measureLatency(input string tag, input bit isLatch, input logic level);
        logic p2, p3;
        int   lat2, lat3;
        p2 = padData2;
        p3 = padData3;
        lat2 = -1;
        lat3 = -1;
        @(posedge clk);
        #($urandom_range(1, 8));
        if (isLatch) padLatch = level;
        else padClk = level;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (lat2 < 0 && padData2 !== p2) lat2 = k;
            if (lat3 < 0 && padData3 !== p3) lat3 = k;
        end
        checkOutput({tag, " latency n=2"}, lat2, 4);
        checkOutput({tag, " latency n=3"}, lat3, 5);
        if (isLatch) modelLatch(level);
        else modelClk(level);
    endtask

    initial begin
        logic [15:0] sampled;
        int          nPulses;

        // Reset behaviour while held and after release
        repeat (3) @(negedge clk);
        checkOutput("in reset pad_data", padData2, 1'b1);
        checkOutput("in reset busy", busy2, 1'b0);
        checkOutput("in reset frame_done", frameDone2, 1'b0);
        checkOutput("in reset stale", stale2, 1'b0);
        doReset(2);
        checkAll("after reset");

        // Normal frame with the classic 0C06 pattern
        writeButtons(16'h0C06);
        applyStimulus(1'b1, 1'b1);
        checkAll("frame latch high");
        applyStimulus(1'b1, 1'b0);
        checkAll("frame latch low");
        sampled = '0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0);
            sampled[i] = ~padData2;
            checkAll("frame fall");
            applyStimulus(1'b0, 1'b1);
            checkAll("frame rise");
        end
        checkOutput("frame sampled bits", sampled, 16'h0C06);
        checkOutput("frame single frame_done", doneCount, 1);

        // Extra clocks after the frame stay at the tail level
        for (int i = 0; i < 4; i++) clkPulse("tail");

        // Button write in the middle of a frame
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) clkPulse("midwrite pre");
        writeButtons(16'hFFFF);
        checkAll("midwrite after we");
        for (int i = 0; i < 4; i++) clkPulse("midwrite post");
        applyStimulus(1'b1, 1'b1);
        checkAll("midwrite relatch");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) clkPulse("midwrite new frame");

        // Restart partway through a frame
        writeButtons(16'h0100);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) clkPulse("restart pre");
        applyStimulus(1'b1, 1'b1);
        checkAll("restart relatch");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) clkPulse("restart post");

        // Reset pulse in the middle of shifting
        writeButtons(16'h5A5A);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) clkPulse("midreset pre");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkOutput("midreset pad_data", padData2, 1'b1);
        checkOutput("midreset busy", busy2, 1'b0);
        clkPulse("midreset no latch");

        // Button write landing in the same cycle as the latch capture
        doReset(3);
        writeButtons(16'h0001);
        @(negedge clk);
        padLatch = 1'b1;
        @(negedge clk);
        @(negedge clk);
        buttons   = 16'hFFFE;
        buttonsWe = 1'b1;
        @(negedge clk);
        buttonsWe = 1'b0;
        @(negedge clk);
        checkOutput("same-cycle old bit0", padData2, 1'b0);
        @(negedge clk);
        checkOutput("same-cycle reload bit0", padData2, 1'b1);
        modelLatch(1'b1);
        modelWrite(16'hFFFE);
        repeat (HOLD) @(negedge clk);
        checkAll("same-cycle settled");
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) clkPulse("same-cycle frame");

        // Pin-to-data latency for both synchronizer depths
        for (int r = 0; r < 3; r++) begin
            doReset(2);
            writeButtons(16'h0001);
            measureLatency("latch rise", 1'b1, 1'b1);
            checkAll("latency after latch");
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
            measureLatency("clk rise", 1'b0, 1'b1);
            checkAll("latency after clk");
        end

        // Randomized console traffic
        doReset(2);
        for (int f = 0; f < 14; f++) begin
            writeButtons(16'($urandom));
            applyStimulus(1'b1, 1'b1);
            checkAll("rnd latch high");
            if ($urandom_range(0, 3) == 0) begin
                writeButtons(16'($urandom));
                checkAll("rnd we while latched");
            end
            if ($urandom_range(0, 3) == 0) clkPulse("rnd clk while latched");
            applyStimulus(1'b1, 1'b0);
            checkAll("rnd latch low");
            nPulses = $urandom_range(0, 20);
            for (int b = 0; b < nPulses; b++) begin
                clkPulse("rnd shift");
                if ($urandom_range(0, 7) == 0) begin
                    writeButtons(16'($urandom));
                    checkAll("rnd we");
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                doReset(2);
                checkAll("rnd reset");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
